// File: rtl/pile_bank_pkg.sv
// pile_bank shared types and helpers.
// Optional input synchroniser: PILE_BANK_SYNC_IN_EN.
package pile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    PUT  = 2'd2
  } state_t;

  function automatic int height_width(input int max_h);
    return $clog2(max_h + 1);
  endfunction

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Field i of a packed height vector, zero-extended to 4 bits.
  function automatic logic [3:0] get_field(
    input logic [31:0] v,
    input int          i,
    input int          hw
  );
    logic [31:0] t;
    logic [31:0] m;
    t = v >> (i * hw);
    m = (32'd1 << hw) - 32'd1;
    return t[3:0] & m[3:0];
  endfunction

endpackage

// File: rtl/pile_bank_if.sv
// Button/command and status bundle of the pile bank.
// Widths follow NUM_PILES and MAX_HEIGHT.
interface pile_bank_if
  import pile_pkg::*;
#(
  parameter int NUM_PILES  = 3,
  parameter int MAX_HEIGHT = 6
);
  localparam int HW = height_width(MAX_HEIGHT);
  localparam int SW = sel_width(NUM_PILES);

  logic                    plus;
  logic                    moins;
  logic                    move;
  logic [SW-1:0]           sel;
  logic [SW-1:0]           dst;
  logic [NUM_PILES*HW-1:0] hauteur;
  logic [NUM_PILES-1:0]    full;
  logic [NUM_PILES-1:0]    empty;
  logic                    busy;
  logic                    err;

  modport master (
    output plus, moins, move, sel, dst,
    input  hauteur, full, empty, busy, err
  );

  modport slave (
    input  plus, moins, move, sel, dst,
    output hauteur, full, empty, busy, err
  );

endinterface

// File: rtl/pile_bank_edge.sv
// pile_edge: level input to one-cycle rising-edge pulse.
// PILE_BANK_SYNC_IN_EN adds a 2-flop synchroniser in front.
module pile_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_evt
);

  logic w_s;
  logic r_q;

`ifdef PILE_BANK_SYNC_IN_EN
  logic r_s1;
  logic r_s2;

  // two-flop synchroniser for an asynchronous button level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign w_s = r_s2;
`else
  assign w_s = i_d;
`endif

  // level history; cleared so a level held through reset fires
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= w_s;
  end

  assign o_evt = w_s & ~r_q;

endmodule

// File: rtl/pile_bank.sv
// pile_bank: saturating brick-height counters with a move FSM.
// Optional input synchroniser: PILE_BANK_SYNC_IN_EN.
module pile_bank
  import pile_pkg::*;
#(
  parameter int NUM_PILES  = 3,
  parameter int MAX_HEIGHT = 6
) (
  input  logic        clk,
  input  logic        reset,
  pile_bank_if.slave  bus
);

  localparam int HW = height_width(MAX_HEIGHT);
  localparam int SW = sel_width(NUM_PILES);
  localparam logic [HW-1:0] MAXH = HW'(MAX_HEIGHT);
  localparam logic [HW-1:0] ONE  = HW'(1);

  logic w_evt_plus;
  logic w_evt_moins;
  logic w_evt_move;

  pile_edge u_plus (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (bus.plus),
    .o_evt (w_evt_plus)
  );

  pile_edge u_moins (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (bus.moins),
    .o_evt (w_evt_moins)
  );

  pile_edge u_move (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (bus.move),
    .o_evt (w_evt_move)
  );

  logic [SW-1:0] w_sel;
  logic [SW-1:0] w_dst;

`ifdef PILE_BANK_SYNC_IN_EN
  logic [SW-1:0] r_sel1;
  logic [SW-1:0] r_sel2;
  logic [SW-1:0] r_dst1;
  logic [SW-1:0] r_dst2;

  // delay indices to line up with the synchronised events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel1 <= '0;
      r_sel2 <= '0;
      r_dst1 <= '0;
      r_dst2 <= '0;
    end else begin
      r_sel1 <= bus.sel;
      r_sel2 <= r_sel1;
      r_dst1 <= bus.dst;
      r_dst2 <= r_dst1;
    end
  end

  assign w_sel = r_sel2;
  assign w_dst = r_dst2;
`else
  assign w_sel = bus.sel;
  assign w_dst = bus.dst;
`endif

  state_t               r_state;
  logic [HW-1:0]        r_h [NUM_PILES];
  logic [NUM_PILES-1:0] r_full;
  logic [NUM_PILES-1:0] r_empty;
  logic [SW-1:0]        r_src;
  logic [SW-1:0]        r_dst;
  logic                 r_busy;
  logic                 r_err;

  logic          w_sel_ok;
  logic          w_dst_ok;
  logic [SW-1:0] w_si;
  logic [SW-1:0] w_di;
  logic          w_move_ok;

  assign w_sel_ok = int'(w_sel) < NUM_PILES;
  assign w_dst_ok = int'(w_dst) < NUM_PILES;
  assign w_si     = w_sel_ok ? w_sel : '0;
  assign w_di     = w_dst_ok ? w_dst : '0;

  assign w_move_ok = w_sel_ok && w_dst_ok
                  && (w_sel != w_dst)
                  && !r_empty[w_si]
                  && !r_full[w_di];

  // request arbitration, move sequencing and counter updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_full  <= '0;
      r_empty <= '1;
      for (int i = 0; i < NUM_PILES; i++) r_h[i] <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_evt_move) begin
            r_src <= w_si;
            r_dst <= w_di;
            if (w_move_ok) begin
              r_state <= TAKE;
              r_busy  <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_evt_plus && w_evt_moins) begin
            r_err <= 1'b0;
          end else if (w_evt_plus) begin
            if (w_sel_ok && !r_full[w_si]) begin
              r_h[w_si]     <= r_h[w_si] + ONE;
              r_empty[w_si] <= 1'b0;
              r_full[w_si]  <= (r_h[w_si] + ONE) == MAXH;
            end else begin
              r_err <= 1'b1;
            end
          end else if (w_evt_moins) begin
            if (w_sel_ok && !r_empty[w_si]) begin
              r_h[w_si]     <= r_h[w_si] - ONE;
              r_full[w_si]  <= 1'b0;
              r_empty[w_si] <= (r_h[w_si] - ONE) == '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        TAKE: begin
          r_h[r_src]     <= r_h[r_src] - ONE;
          r_full[r_src]  <= 1'b0;
          r_empty[r_src] <= (r_h[r_src] - ONE) == '0;
          r_state        <= PUT;
        end
        PUT: begin
          r_h[r_dst]     <= r_h[r_dst] + ONE;
          r_empty[r_dst] <= 1'b0;
          r_full[r_dst]  <= (r_h[r_dst] + ONE) == MAXH;
          r_state        <= IDLE;
          r_busy         <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PILES; g++) begin : g_out
    assign bus.hauteur[g*HW +: HW] = r_h[g];
  end

  assign bus.full  = r_full;
  assign bus.empty = r_empty;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_pile_bank.sv
// Self-checking bench for pile_bank (default build).
// Event-level pile model plus directed literal checks.
module tb_pile_bank;

  localparam int NP = 3;
  localparam int MH = 6;
  localparam int HW = 3;

  logic clk;
  logic reset;

  pile_bank_if #(.NUM_PILES(NP), .MAX_HEIGHT(MH)) bus ();

  pile_bank #(.NUM_PILES(NP), .MAX_HEIGHT(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int fld(input int i);
    return int'(bus.hauteur[i*HW +: HW]);
  endfunction

  // pile model: heights, move phase, previous levels
  int mh [NP];
  int ph;
  int ms;
  int md;
  bit m_err;
  bit pp, pm, pv;

  always @(posedge clk or posedge reset) begin
    bit ep, en, ev;
    int s, d;
    if (reset) begin
      for (int i = 0; i < NP; i++) mh[i] = 0;
      ph = 0; ms = 0; md = 0; m_err = 0;
      pp = 0; pm = 0; pv = 0;
    end else begin
      ep = bus.plus  && !pp;
      en = bus.moins && !pm;
      ev = bus.move  && !pv;
      s = int'(bus.sel);
      d = int'(bus.dst);
      m_err = 0;
      if (ph == 1) begin
        mh[ms]--; ph = 2;
      end else if (ph == 2) begin
        mh[md]++; ph = 0;
      end else if (ev) begin
        if (s < NP && d < NP && s != d && mh[s] > 0 && mh[d] < MH) begin
          ms = s; md = d; ph = 1;
        end else m_err = 1;
      end else if (ep && en) begin
        m_err = 0;
      end else if (ep) begin
        if (s < NP && mh[s] < MH) mh[s]++;
        else m_err = 1;
      end else if (en) begin
        if (s < NP && mh[s] > 0) mh[s]--;
        else m_err = 1;
      end
      pp = bus.plus; pm = bus.moins; pv = bus.move;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int eh, ef, ee;
    if (!reset) begin
      eh = 0; ef = 0; ee = 0;
      for (int i = 0; i < NP; i++) begin
        eh |= mh[i] << (i * HW);
        if (mh[i] == MH) ef |= 1 << i;
        if (mh[i] == 0)  ee |= 1 << i;
      end
      chk("cyc_hauteur", int'(bus.hauteur), eh);
      chk("cyc_full", int'(bus.full), ef);
      chk("cyc_empty", int'(bus.empty), ee);
      chk("cyc_busy", int'(bus.busy), (ph != 0) ? 1 : 0);
      chk("cyc_err", int'(bus.err), int'(m_err));
    end
  end

  task automatic press(input int kind, input int s, input int d);
    @(posedge clk); #2;
    bus.sel = 2'(s);
    bus.dst = 2'(d);
    case (kind)
      0:       bus.plus  = 1'b1;
      1:       bus.moins = 1'b1;
      default: bus.move  = 1'b1;
    endcase
    @(posedge clk); #2;
    bus.plus  = 1'b0;
    bus.moins = 1'b0;
    bus.move  = 1'b0;
  endtask

  task automatic heights(input string nm, input int a, input int b, input int c);
    chk({nm, "_h0"}, fld(0), a);
    chk({nm, "_h1"}, fld(1), b);
    chk({nm, "_h2"}, fld(2), c);
  endtask

  int refs [3][2] = '{'{0, 2}, '{1, 1}, '{3, 0}};

  initial begin
    reset = 1'b1;
    bus.plus = 1'b0; bus.moins = 1'b0; bus.move = 1'b0;
    bus.sel = '0; bus.dst = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_hauteur", int'(bus.hauteur), 0);
    chk("rst_empty", int'(bus.empty), 7);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.err), 0);

    // seven presses on pile 1: 1..6 then refused
    for (int k = 0; k < 7; k++) begin
      press(0, 1, 0);
      @(negedge clk);
      if (k < 6) begin
        chk("sat_h1", fld(1), k + 1);
        chk("sat_err", int'(bus.err), 0);
      end else begin
        chk("sat_h1_top", fld(1), 6);
        chk("sat_err_top", int'(bus.err), 1);
        chk("sat_full1", int'(bus.full[1]), 1);
      end
    end

    // held plus: a single increment
    @(posedge clk); #2;
    bus.sel = 2'd0; bus.plus = 1'b1;
    repeat (20) @(posedge clk);
    #2 bus.plus = 1'b0;
    @(negedge clk);
    chk("hold_h0", fld(0), 1);

    // plus and moins together at height 3
    for (int k = 0; k < 3; k++) press(0, 2, 0);
    @(posedge clk); #2;
    bus.sel = 2'd2; bus.plus = 1'b1; bus.moins = 1'b1;
    @(posedge clk); #2;
    bus.plus = 1'b0; bus.moins = 1'b0;
    @(negedge clk);
    chk("both_h2", fld(2), 3);
    chk("both_err", int'(bus.err), 0);

    // set up piles (2,0,6)
    press(0, 0, 0);
    for (int k = 0; k < 6; k++) press(1, 1, 0);
    for (int k = 0; k < 3; k++) press(0, 2, 0);
    @(negedge clk);
    heights("setup", 2, 0, 6);

    // move 0 -> 1
    press(2, 0, 1);
    @(negedge clk);
    chk("mv_busy0", int'(bus.busy), 1);
    heights("mv_start", 2, 0, 6);
    @(negedge clk);
    chk("mv_busy1", int'(bus.busy), 1);
    heights("mv_take", 1, 0, 6);
    @(negedge clk);
    chk("mv_busy2", int'(bus.busy), 0);
    heights("mv_put", 1, 1, 6);

    // refused moves
    for (int r = 0; r < 3; r++) begin
      press(2, refs[r][0], refs[r][1]);
      @(negedge clk);
      chk("ref_err", int'(bus.err), 1);
      chk("ref_busy", int'(bus.busy), 0);
      heights("ref", 1, 1, 6);
      @(negedge clk);
      chk("ref_err_end", int'(bus.err), 0);
    end

    // reset during TAKE
    press(2, 0, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmv_hauteur", int'(bus.hauteur), 0);
    chk("rstmv_busy", int'(bus.busy), 0);
    chk("rstmv_empty", int'(bus.empty), 7);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("post_busy", int'(bus.busy), 0);
    press(0, 0, 0);
    @(negedge clk);
    heights("post", 1, 0, 0);
    chk("post_busy2", int'(bus.busy), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pile_bank.md
Name: pile_bank

Overview:
- Bank of NUM_PILES independent brick-height counters. Each counter saturates at 0 and MAX_HEIGHT.
- Operated by push-button style level inputs. Rising edges are detected internally, so one press equals one brick.
- Adds a two-phase "move" operation that transfers one brick between piles.
- Sits between the debounced button/switch inputs and the display/scoring logic of the brick game.

Parameters:
- NUM_PILES, 3, number of piles (1..8).
- MAX_HEIGHT, 6, saturation height of every pile (1..15).
- HW (localparam), $clog2(MAX_HEIGHT+1), width of one height field.
- SW (localparam), max(1,$clog2(NUM_PILES)), width of a pile index.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- plus  in  1  level; rising edge adds one brick to pile sel.
- moins  in  1  level; rising edge removes one brick from pile sel.
- move  in  1  level; rising edge moves one brick from pile sel to pile dst.
- sel  in  SW  source / target pile index; sampled on the detecting edge.
- dst  in  SW  destination pile index for move.
- hauteur  out  NUM_PILES*HW  packed heights; pile i occupies bits [i*HW +: HW].
- full  out  NUM_PILES  bit i = (height i == MAX_HEIGHT).
- empty  out  NUM_PILES  bit i = (height i == 0).
- busy  out  1  high while a move is in progress.
- err  out  1  one-cycle pulse on any refused request.

Behaviour:
- Reset (async, active-high):
  - all heights 0, so empty is all ones and full is all zeros.
  - busy=0, err=0, FSM in IDLE.
  - edge-detect history registers cleared to 0, so an input held high through reset release counts as a new edge.
- Edge detection: evt_x = x & ~x_q, where x_q is x registered every clock. The height changes on the same clk edge at which the high level is first sampled, so latency is 1 edge.
- All outputs are registered.
- FSM states: IDLE, TAKE, PUT.
- IDLE, events and priority:
  - evt_move > (evt_plus, evt_moins); only one class of event is acted on per cycle.
  - evt_plus & evt_moins in the same cycle: no change, no err (net zero).
  - plus alone: if sel < NUM_PILES and not full[sel], height[sel] += 1. Otherwise height is unchanged and err pulses.
  - moins alone: if sel valid and not empty[sel], height[sel] -= 1. Otherwise unchanged and err pulses.
  - move: latch sel/dst into src_r/dst_r.
    - If both are valid, src != dst, src not empty and dst not full: go to TAKE with busy=1.
    - Otherwise stay in IDLE and pulse err.
  - Lower-priority events arriving in the same cycle as a move are dropped, with no err.
- TAKE (1 cycle): height[src_r] -= 1, then go to PUT.
- PUT (1 cycle): height[dst_r] += 1, then go to IDLE with busy=0.
- During TAKE/PUT, new plus/moins/move edges are ignored: no change, no err. Edge history still updates, so held buttons do not re-fire later.
- Move timing: the brick is absent from both piles for exactly one cycle (after TAKE). Total busy time is 2 cycles.
- Heights never wrap. Arithmetic is HW-bit unsigned and the saturation checks precede every update.
- Reset asserted mid-move aborts immediately; the partially moved brick is lost because all heights return to 0.
- Invalid sel (>= NUM_PILES, possible when NUM_PILES is not a power of 2) is always refused with err.

Optional Feature:
- Macro: PILE_BANK_SYNC_IN_EN.
- Defined: plus, moins and move each pass through a 2-flop synchroniser, reset to 0, before edge detection. Event latency becomes 3 edges from the asynchronous input rising to the height update. sel/dst are captured alongside the synchronised events.
- Undefined: inputs are assumed synchronous to clk, and latency is 1 edge as above.

Decomposition:
- Package pile_pkg holds:
  - FSM state enum (IDLE, TAKE, PUT);
  - constant function for the height width (clog2);
  - a helper function to extract field i from the packed hauteur vector.
- Sub-module pile_edge: one input bit, optional synchroniser under PILE_BANK_SYNC_IN_EN, rising-edge pulse out. It is instantiated three times.
- Counters and FSM stay in pile_bank.

Test Plan:
- Reset, then plus pulsed 7 times on sel=1 with defaults: hauteur[1] steps 1..6. The 7th press leaves it at 6 with an err pulse, and full[1]=1.
- plus held high for 20 cycles on sel=0: height 0 goes 0→1 only. A single err-free increment.
- plus and moins rising in the same cycle on sel=2 at height 3: height stays 3 and err=0.
- Piles at (2,0,6); move with sel=0, dst=1:
  - busy is high for 2 cycles;
  - after TAKE the heights are (1,0,6);
  - after PUT the heights are (1,1,6).
- Refused moves, each giving err for 1 cycle, busy=0 and heights unchanged:
  - sel=0, dst=2 (dst full);
  - sel=1, dst=1 (src equals dst);
  - sel=3 (invalid index).
- Assert reset during TAKE: all heights are 0 asynchronously (before the next clk edge), busy=0, and the FSM returns to IDLE.
